// File: rtl/ps2_kbd_event_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_event_fifo_if
// Description : Read-side handshake of the PS/2 keyboard event FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_kbd_event_fifo_if;
    logic        rd_valid;
    logic        rd_ready;
    logic [17:0] rd_data;

    modport master (
        output rd_valid,
        output rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        output rd_ready
    );
endinterface
`default_nettype wire

// File: rtl/ps2_kbd_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_event_fifo
// Description : PS/2 keyboard receiver with make/break/E0 decode, shift
//               tracking, ASCII mapping and a first-word fall-through FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd_event_fifo #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ps2_clk,
    input  logic                         ps2_data,
    input  logic                         clr_ovf,
    ps2_kbd_event_fifo_if.master         rd,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow,
    output logic                         frame_err,
    output logic                         shift_held
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_TO_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_TO_W-1:0]  c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_BRK     = 2'd1;
    localparam logic [1:0] c_ST_EXT     = 2'd2;
    localparam logic [1:0] c_ST_EXT_BRK = 2'd3;

    // ------------------------------------------------------------------
    // Pin synchronisers (stage 0 newest); idle bus level is high
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   w_fall;
    logic                   w_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign w_fall = r_clk_sync[SYNC_STAGES-1] & ~r_clk_sync[SYNC_STAGES-2];
    assign w_bit  = r_dat_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Frame receiver and watchdog
    // r_shreg after ten bits: [0]=start, [8:1]=data, [9]=parity
    // ------------------------------------------------------------------
    logic [3:0]        r_bit_cnt;
    logic [9:0]        r_shreg;
    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_byte_vld;
    logic [7:0]        r_byte;
    logic              r_frame_err;
    logic              w_frame_ok;
    logic              w_timeout;

    assign w_frame_ok = ~r_shreg[0] & w_bit & (^r_shreg[9:1]);
    assign w_timeout  = (r_bit_cnt != 4'd0) && !w_fall && (r_to_cnt == c_TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt   <= 4'd0;
            r_shreg     <= '0;
            r_to_cnt    <= '0;
            r_byte_vld  <= 1'b0;
            r_byte      <= 8'h00;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_vld  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt <= 4'd0;
                    if (w_frame_ok) begin
                        r_byte_vld <= 1'b1;
                        r_byte     <= r_shreg[8:1];
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_shreg   <= {w_bit, r_shreg[9:1]};
                end
            end else if (r_bit_cnt != 4'd0) begin
                if (w_timeout) begin
                    r_bit_cnt   <= 4'd0;
                    r_to_cnt    <= '0;
                    r_frame_err <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Make/break/extended decoder
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_emit;
    logic       w_ext;
    logic       w_rel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_byte_vld) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_byte == 8'hF0)      w_state_nxt = c_ST_BRK;
                    else if (r_byte == 8'hE0) w_state_nxt = c_ST_EXT;
                end
                c_ST_BRK:     w_state_nxt = c_ST_IDLE;
                c_ST_EXT:     w_state_nxt = (r_byte == 8'hF0) ? c_ST_EXT_BRK : c_ST_IDLE;
                c_ST_EXT_BRK: w_state_nxt = c_ST_IDLE;
                default:      w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_emit = 1'b0;
        w_ext  = 1'b0;
        w_rel  = 1'b0;
        if (r_byte_vld) begin
            case (r_state)
                c_ST_IDLE: w_emit = (r_byte != 8'hF0) && (r_byte != 8'hE0);
                c_ST_BRK: begin
                    w_emit = 1'b1;
                    w_rel  = 1'b1;
                end
                c_ST_EXT: begin
                    w_emit = (r_byte != 8'hF0);
                    w_ext  = 1'b1;
                end
                c_ST_EXT_BRK: begin
                    w_emit = 1'b1;
                    w_ext  = 1'b1;
                    w_rel  = 1'b1;
                end
                default: w_emit = 1'b0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scancode set 2 to ASCII; letters map to lowercase first
    // ------------------------------------------------------------------
    logic [7:0] w_map;
    logic       w_letter;
    logic [7:0] w_ascii;

    always_comb begin
        w_map = 8'h00;
        case (r_byte)
            8'h1C: w_map = 8'h61;  8'h32: w_map = 8'h62;  8'h21: w_map = 8'h63;
            8'h23: w_map = 8'h64;  8'h24: w_map = 8'h65;  8'h2B: w_map = 8'h66;
            8'h34: w_map = 8'h67;  8'h33: w_map = 8'h68;  8'h43: w_map = 8'h69;
            8'h3B: w_map = 8'h6A;  8'h42: w_map = 8'h6B;  8'h4B: w_map = 8'h6C;
            8'h3A: w_map = 8'h6D;  8'h31: w_map = 8'h6E;  8'h44: w_map = 8'h6F;
            8'h4D: w_map = 8'h70;  8'h15: w_map = 8'h71;  8'h2D: w_map = 8'h72;
            8'h1B: w_map = 8'h73;  8'h2C: w_map = 8'h74;  8'h3C: w_map = 8'h75;
            8'h2A: w_map = 8'h76;  8'h1D: w_map = 8'h77;  8'h22: w_map = 8'h78;
            8'h35: w_map = 8'h79;  8'h1A: w_map = 8'h7A;
            8'h45: w_map = 8'h30;  8'h16: w_map = 8'h31;  8'h1E: w_map = 8'h32;
            8'h26: w_map = 8'h33;  8'h25: w_map = 8'h34;  8'h2E: w_map = 8'h35;
            8'h36: w_map = 8'h36;  8'h3D: w_map = 8'h37;  8'h3E: w_map = 8'h38;
            8'h46: w_map = 8'h39;
            8'h29: w_map = 8'h20;  8'h5A: w_map = 8'h0D;  8'h66: w_map = 8'h08;
            default: w_map = 8'h00;
        endcase
    end

    assign w_letter = (w_map >= 8'h61) && (w_map <= 8'h7A);

    always_comb begin
        w_ascii = 8'h00;
        if (!w_ext && !w_rel) begin
            w_ascii = (w_letter && shift_held) ? (w_map & 8'hDF) : w_map;
        end
    end

    // ------------------------------------------------------------------
    // Event register and shift state (bit 0 left, bit 1 right)
    // ------------------------------------------------------------------
    logic        r_evt_vld;
    logic [17:0] r_evt_data;
    logic [1:0]  r_shift_st;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evt_vld  <= 1'b0;
            r_evt_data <= '0;
            r_shift_st <= 2'b00;
        end else begin
            r_evt_vld <= w_emit;
            if (w_emit) begin
                r_evt_data <= {w_ext, w_rel, r_byte, w_ascii};
                if (!w_ext && (r_byte == 8'h12)) r_shift_st[0] <= ~w_rel;
                if (!w_ext && (r_byte == 8'h59)) r_shift_st[1] <= ~w_rel;
            end
        end
    end

    assign shift_held = |r_shift_st;

    // ------------------------------------------------------------------
    // Event FIFO; a pop frees the slot a simultaneous push lands in
    // ------------------------------------------------------------------
    logic [17:0]        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_ovf;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_pop   = !w_empty && rd.rd_ready;
    assign w_push  = r_evt_vld && (!w_full || w_pop);
    assign w_drop  = r_evt_vld && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_evt_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop)       r_ovf <= 1'b1;
            else if (clr_ovf) r_ovf <= 1'b0;
        end
    end

    assign rd.rd_valid = !w_empty;
    assign rd.rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign fifo_count  = r_count;
    assign overflow    = r_ovf;
    assign frame_err   = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_kbd_event_fifo
// Description : Directed bench for the PS/2 keyboard event FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_event_fifo;
    localparam int c_DEPTH = 8;
    localparam int c_SYNC  = 3;
    localparam int c_TO    = 400;
    localparam int c_HALF  = 8;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       clr_ovf  = 1'b0;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       frame_err;
    logic       shift_held;

    int n_pass      = 0;
    int n_fail      = 0;
    int n_checks    = 0;
    int n_err_pulse = 0;
    int err_base    = 0;

    ps2_kbd_event_fifo_if bus ();

    ps2_kbd_event_fifo #(
        .FIFO_DEPTH  (c_DEPTH),
        .SYNC_STAGES (c_SYNC),
        .TIMEOUT_CYC (c_TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .clr_ovf    (clr_ovf),
        .rd         (bus),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .shift_held (shift_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_err) n_err_pulse <= n_err_pulse + 1;
    end

    function automatic logic [31:0] ev(input logic ext, input logic rel,
                                       input logic [7:0] code, input logic [7:0] asc);
        return {14'b0, ext, rel, code, asc};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        chk(tag, 32'(bus.rd_data), exp);
        bus.rd_ready = 1'b1;
        tick(1);
        bus.rd_ready = 1'b0;
    endtask

    // mode 0: plain, 1: check rd_valid latency, 2: pop exactly in the push cycle
    task automatic send_frame(input logic [7:0] b, input logic bad, input int mode, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            tick(c_HALF);
            ps2_clk = 1'b0;
            if (i == 10 && mode == 1) begin
                tick(4);
                chk("lat_before", 32'(bus.rd_valid), 0);
                tick(1);
                chk("lat_rise", 32'(bus.rd_valid), 1);
                tick(c_HALF - 5);
            end else if (i == 10 && mode == 2) begin
                tick(4);
                chk("full_pre_count", 32'(fifo_count), 8);
                bus.rd_ready = 1'b1;
                tick(1);
                bus.rd_ready = 1'b0;
                chk("full_pushpop_count", 32'(fifo_count), 8);
                chk("full_pushpop_ovf", 32'(overflow), 0);
                tick(c_HALF - 5);
            end else begin
                tick(c_HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(2 * c_HALF);
    endtask

    task automatic press(input logic [7:0] b);
        send_frame(b, 1'b0, 0, 11);
    endtask

    initial begin
        bus.rd_ready = 1'b0;
        rst = 1'b1;
        tick(3);
        chk("rst_valid", 32'(bus.rd_valid), 0);
        chk("rst_data", 32'(bus.rd_data), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_shift", 32'(shift_held), 0);
        rst = 1'b0;
        tick(2);

        // single make code with latency check
        send_frame(8'h1C, 1'b0, 1, 11);
        chk("a_count", 32'(fifo_count), 1);
        pop_chk("a_entry", ev(0, 0, 8'h1C, 8'h61));
        chk("a_empty", 32'(bus.rd_valid), 0);

        // shift tracking and break codes
        press(8'h12);
        chk("shift_make", 32'(shift_held), 1);
        press(8'h1C);
        press(8'hF0);
        press(8'h1C);
        press(8'hF0);
        press(8'h12);
        chk("shift_break", 32'(shift_held), 0);
        chk("shift_count", 32'(fifo_count), 4);
        pop_chk("shift_e0", ev(0, 0, 8'h12, 8'h00));
        pop_chk("shift_e1", ev(0, 0, 8'h1C, 8'h41));
        pop_chk("shift_e2", ev(0, 1, 8'h1C, 8'h00));
        pop_chk("shift_e3", ev(0, 1, 8'h12, 8'h00));

        // extended make and break
        press(8'hE0);
        press(8'h75);
        press(8'hE0);
        press(8'hF0);
        press(8'h75);
        chk("ext_count", 32'(fifo_count), 2);
        pop_chk("ext_make", ev(1, 0, 8'h75, 8'h00));
        pop_chk("ext_break", ev(1, 1, 8'h75, 8'h00));
        press(8'h1C);
        pop_chk("ext_idle", ev(0, 0, 8'h1C, 8'h61));

        // bad parity
        err_base = n_err_pulse;
        send_frame(8'h1C, 1'b1, 0, 11);
        chk("perr_pulses", 32'(n_err_pulse - err_base), 1);
        chk("perr_count", 32'(fifo_count), 0);

        // stalled frame
        err_base = n_err_pulse;
        send_frame(8'h1C, 1'b0, 0, 6);
        tick(c_TO + 50);
        chk("to_pulses", 32'(n_err_pulse - err_base), 1);
        press(8'h1C);
        chk("to_count", 32'(fifo_count), 1);
        pop_chk("to_entry", ev(0, 0, 8'h1C, 8'h61));

        // overflow
        for (int i = 0; i < c_DEPTH + 2; i++) press(8'h16);
        chk("ovf_count", 32'(fifo_count), c_DEPTH);
        chk("ovf_flag", 32'(overflow), 1);
        for (int i = 0; i < c_DEPTH; i++) pop_chk("ovf_drain", ev(0, 0, 8'h16, 8'h31));
        chk("ovf_empty", 32'(fifo_count), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk("ovf_clear", 32'(overflow), 0);

        // push and pop together while full
        for (int i = 0; i < c_DEPTH; i++) press(8'h16);
        chk("full_count", 32'(fifo_count), c_DEPTH);
        send_frame(8'h1C, 1'b0, 2, 11);
        for (int i = 0; i < c_DEPTH - 1; i++) pop_chk("full_drain", ev(0, 0, 8'h16, 8'h31));
        pop_chk("full_tail", ev(0, 0, 8'h1C, 8'h61));
        chk("full_empty", 32'(fifo_count), 0);

        // reset mid-frame with shift held and an entry queued
        press(8'h12);
        press(8'h1C);
        send_frame(8'h1C, 1'b0, 0, 5);
        rst = 1'b1;
        #2;
        chk("mrst_valid", 32'(bus.rd_valid), 0);
        chk("mrst_data", 32'(bus.rd_data), 0);
        chk("mrst_count", 32'(fifo_count), 0);
        chk("mrst_shift", 32'(shift_held), 0);
        chk("mrst_ferr", 32'(frame_err), 0);
        tick(1);
        rst = 1'b0;
        tick(2);
        press(8'h1C);
        chk("post_rst_count", 32'(fifo_count), 1);
        pop_chk("post_rst_entry", ev(0, 0, 8'h1C, 8'h61));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
